// File: rtl/iter_shift_pkg.sv
// Shared definitions for the iterative shifter: mode codes, FSM states and
// the per-cycle shift-amount helper.
package iter_shift_pkg;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bits to move this cycle: never more than the datapath step, never
    // more than what is still outstanding.
    function automatic int unsigned step_amt(input int unsigned step,
                                             input int unsigned rem);
        return (rem < step) ? rem : step;
    endfunction

endpackage

// File: rtl/iter_shift_unit_step.sv
// One combinational shift step: moves data by k bits in the given mode and
// reports the last bit that left the register (0 when k is 0).
module shift_step
    import iter_shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] k,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   data_out,
    output logic               out_bit
);

    logic [WIDTH:0]        lsl_ext;
    logic [WIDTH:0]        rsh_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [WIDTH-1:0]      ror_val;

    // One guard bit beyond the register catches the last bit shifted out;
    // for right shifts and rotates that bit is data_in[k-1].
    always_comb begin
        lsl_ext  = {1'b0, data_in} << k;
        rsh_ext  = {data_in, 1'b0} >> k;
        asr_ext  = $signed({data_in, 1'b0}) >>> k;
        ror_val  = (data_in >> k) | (data_in << (WIDTH - int'(k)));
        data_out = data_in;
        out_bit  = 1'b0;
        case (mode)
            MODE_LSL: begin
                data_out = lsl_ext[WIDTH-1:0];
                out_bit  = lsl_ext[WIDTH];
            end
            MODE_LSR: begin
                data_out = rsh_ext[WIDTH:1];
                out_bit  = rsh_ext[0];
            end
            MODE_ASR: begin
                data_out = asr_ext[WIDTH:1];
                out_bit  = asr_ext[0];
            end
            default: begin
                data_out = ror_val;
                out_bit  = rsh_ext[0];
            end
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: accepts an operand and shift amount on start, then
// shifts up to STEP bits per cycle until the amount is exhausted.
//
// Handshake: start is sampled only while busy=0 (state IDLE); starts while
// busy, including in the done cycle, are dropped. done (and Shift_Flag)
// pulses for exactly one cycle with Shift_out/carry_out/zero_out valid;
// those outputs then hold until the next accepted start.
module iter_shift_unit
    import iter_shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               op_sel,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   Shift_out,
    output logic               Shift_Flag,
    output logic               carry_out,
    output logic               zero_out,
    output logic [1:0]         dbg_state
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         mode_q, mode_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic [SHAMT_W-1:0] k;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   step_data;
    logic               step_bit;

    shift_step #(
        .WIDTH  (WIDTH),
        .SHAMT_W(SHAMT_W)
    ) u_step (
        .data_in (work_q),
        .k       (k),
        .mode    (mode_q),
        .data_out(step_data),
        .out_bit (step_bit)
    );

    // Next-state, work-register and flag updates for the start/shift/done sequence.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        k       = SHAMT_W'(step_amt(STEP, 32'(rem_q)));
        operand = op_sel ? B : A;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = operand;
                    mode_d  = mode;
                    rem_d   = shamt;
                    carry_d = 1'b0;
                    if (shamt == '0) begin
                        state_d = ST_DONE;
                        zero_d  = (operand == '0);
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = step_data;
                carry_d = step_bit;
                rem_d   = rem_q - k;
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                    zero_d  = (step_data == '0);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_LSL;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        Shift_Flag = done;
        Shift_out  = work_q;
        carry_out  = carry_q;
        zero_out   = zero_q;
        dbg_state  = state_q;
    end

endmodule
